// File: rtl/intr_sync_ctrl_pkg.sv
// rtl/intr_sync_ctrl_pkg.sv - shared constants and helpers for the interrupt front-end
//
// Purpose: sense-mode encodings and a width helper used by intr_sync_ctrl and
// intr_chan_filter.
// Contents:
//   INTR_MODE_*  2-bit per-channel sense mode encodings
//   clog2_min1   ceil(log2(n)), never less than 1 (so a vector is always 1 bit or more)
package intr_pkg;

  localparam logic [1:0] INTR_MODE_LEVEL = 2'b00;
  localparam logic [1:0] INTR_MODE_RISE  = 2'b01;
  localparam logic [1:0] INTR_MODE_FALL  = 2'b10;
  localparam logic [1:0] INTR_MODE_BOTH  = 2'b11;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_sync_ctrl_if.sv
// rtl/intr_sync_ctrl_if.sv - clear/status bus between interrupt front-end and CPU glue
//
// Purpose: groups the clear strobe and the pending/irq status outputs.
// Signals:
//   clr_valid  one-cycle clear strobe
//   clr_mask   write-1-to-clear mask, qualified by clr_valid
//   pending    per-channel pending status
//   irq        aggregated level interrupt
//   irq_id     lowest active channel index
// Modports:
//   master  CPU/PLIC side: drives the clear, observes status
//   slave   intr_sync_ctrl side: accepts the clear, drives status
interface intr_sync_ctrl_if #(
  parameter int INTR_WIDTH = 8,
  parameter int ID_WIDTH   = 3
);

  logic                  clr_valid;
  logic [INTR_WIDTH-1:0] clr_mask;
  logic [INTR_WIDTH-1:0] pending;
  logic                  irq;
  logic [ID_WIDTH-1:0]   irq_id;

  modport master (
    output clr_valid,
    output clr_mask,
    input  pending,
    input  irq,
    input  irq_id
  );

  modport slave (
    input  clr_valid,
    input  clr_mask,
    output pending,
    output irq,
    output irq_id
  );

endinterface

// File: rtl/intr_sync_ctrl_chan_filter.sv
// rtl/intr_sync_ctrl_chan_filter.sv - per-channel synchroniser, glitch filter and edge detector
//
// Purpose: brings one asynchronous interrupt line into the clk domain, rejects
// pulses shorter than the filter length and flags accepted level changes.
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   intr_in  in   raw asynchronous line
//   filt     out  filtered (accepted) level, registered
//   rise     out  one-cycle flag: filt went 0->1
//   fall     out  one-cycle flag: filt went 1->0
module intr_chan_filter
  import intr_pkg::*;
#(
  parameter int SYNC_STAGE    = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic clk,
  input  logic rstn,
  input  logic intr_in,
  output logic filt,
  output logic rise,
  output logic fall
);

  // 0 and 1 both mean "accept after one cycle", i.e. no filtering.
  localparam int F  = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
  localparam int CW = clog2_min1(F + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(F - 1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] sync_q;
  logic          s;
  logic [CW-1:0] cnt_q;
  logic          filt_q;
  logic          filt_d_q;

  assign s = sync_q[SYNC_STAGE-1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      filt_d_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGE-2:0], intr_in};
      filt_d_q <= filt_q;
      // The counter tracks how long s has disagreed with the accepted level;
      // the cycle it reaches F consecutive disagreements the new level is taken.
      if (s != filt_q) begin
        if (cnt_q == CNT_LAST) begin
          filt_q <= s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign filt = filt_q;
  assign rise = filt_q & ~filt_d_q;
  assign fall = ~filt_q & filt_d_q;

endmodule

// File: rtl/intr_sync_ctrl.sv
// rtl/intr_sync_ctrl.sv - interrupt front-end: sync, filter, sense mode, pending and IRQ aggregation
//
// Purpose: per-channel sync/filter, programmable sense, sticky pending bits,
// one aggregated level irq and the lowest-index active channel id.
// Ports:
//   clk       in   single clock
//   rstn      in   synchronous active-low reset
//   intr_in   in   raw interrupt lines (asynchronous)
//   cfg_mode  in   per-channel sense [2i+1:2i]: 00 level, 01 rise, 10 fall, 11 both
//   cfg_en    in   per-channel enable, gates capture and reporting
//   bus       slave modport: clr_valid/clr_mask in, pending/irq/irq_id out
module intr_sync_ctrl
  import intr_pkg::*;
#(
  parameter int INTR_WIDTH    = 8,
  parameter int SYNC_STAGE    = 2,
  parameter int FILTER_CYCLES = 0,
  parameter int ID_WIDTH      = clog2_min1(INTR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [INTR_WIDTH-1:0]   intr_in,
  input  logic [2*INTR_WIDTH-1:0] cfg_mode,
  input  logic [INTR_WIDTH-1:0]   cfg_en,
  intr_sync_ctrl_if.slave         bus
);

  logic [INTR_WIDTH-1:0] filt;
  logic [INTR_WIDTH-1:0] rise;
  logic [INTR_WIDTH-1:0] fall;
  logic [INTR_WIDTH-1:0] pending_q;
  logic [INTR_WIDTH-1:0] pending_nxt;
  logic [INTR_WIDTH-1:0] active;
  logic                  irq_q;
  logic [ID_WIDTH-1:0]   irq_id_q;
  logic [ID_WIDTH-1:0]   id_nxt;

  for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_chan
    intr_chan_filter #(
      .SYNC_STAGE    (SYNC_STAGE),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
      .clk     (clk),
      .rstn    (rstn),
      .intr_in (intr_in[i]),
      .filt    (filt[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  always_comb begin
    pending_nxt = pending_q;
    for (int i = 0; i < INTR_WIDTH; i++) begin
      logic hit;
      hit = 1'b0;
      case (cfg_mode[2*i +: 2])
        INTR_MODE_RISE: hit = rise[i];
        INTR_MODE_FALL: hit = fall[i];
        INTR_MODE_BOTH: hit = rise[i] | fall[i];
        default:        hit = 1'b0;
      endcase
      if (cfg_mode[2*i +: 2] == INTR_MODE_LEVEL) begin
        // Level sense simply mirrors the filtered line; clears cannot stick.
        pending_nxt[i] = filt[i] & cfg_en[i];
      end else if (cfg_en[i] && hit) begin
        // A new edge beats a simultaneous clear so the event is never lost.
        pending_nxt[i] = 1'b1;
      end else if (bus.clr_valid && bus.clr_mask[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Disabled channels keep their pending bit but are hidden from irq/irq_id.
  assign active = pending_q & cfg_en;

  always_comb begin
    id_nxt = '0;
    for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_nxt = ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      pending_q <= pending_nxt;
      irq_q     <= |active;
      irq_id_q  <= id_nxt;
    end
  end

  assign bus.pending = pending_q;
  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;

endmodule

// File: tb/tb_intr_sync_ctrl.sv
// tb/tb_intr_sync_ctrl.sv - self-checking bench for intr_sync_ctrl
module tb_intr_sync_ctrl;

  logic        clk;
  logic        rstn;
  logic [7:0]  intr_in;
  logic [15:0] cfg_mode;
  logic [7:0]  cfg_en;
  logic        clr_valid;
  logic [7:0]  clr_mask;

  int checks;
  int errors;

  intr_sync_ctrl_if #(.INTR_WIDTH(8), .ID_WIDTH(3)) bus ();
  intr_sync_ctrl_if #(.INTR_WIDTH(8), .ID_WIDTH(3)) bus_f4 ();

  assign bus.clr_valid    = clr_valid;
  assign bus.clr_mask     = clr_mask;
  assign bus_f4.clr_valid = clr_valid;
  assign bus_f4.clr_mask  = clr_mask;

  intr_sync_ctrl #(
    .INTR_WIDTH    (8),
    .SYNC_STAGE    (2),
    .FILTER_CYCLES (0),
    .ID_WIDTH      (3)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .intr_in  (intr_in),
    .cfg_mode (cfg_mode),
    .cfg_en   (cfg_en),
    .bus      (bus.slave)
  );

  intr_sync_ctrl #(
    .INTR_WIDTH    (8),
    .SYNC_STAGE    (2),
    .FILTER_CYCLES (4),
    .ID_WIDTH      (3)
  ) dut_f4 (
    .clk      (clk),
    .rstn     (rstn),
    .intr_in  (intr_in),
    .cfg_mode (cfg_mode),
    .cfg_en   (cfg_en),
    .bus      (bus_f4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] intr_in;
    logic       clr_valid;
    logic [7:0] clr_mask;
    logic [7:0] exp_pending;
    logic       exp_irq;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs [12];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] p, input logic q, input logic [2:0] id);
    check({name, "_pending"}, 32'(bus.pending), 32'(p));
    check({name, "_irq"},     32'(bus.irq),     32'(q));
    check({name, "_id"},      32'(bus.irq_id),  32'(id));
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    intr_in   = 8'h00;
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    tick(1);
    rstn = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    intr_in   = 8'h00;
    cfg_mode  = 16'h5555;
    cfg_en    = 8'hFF;
    clr_valid = 1'b0;
    clr_mask  = 8'h00;

    // T1 + basic clear: rising on ch3, hold, fall, then clear.
    vecs[0]  = '{8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[1]  = '{8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[2]  = '{8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};
    vecs[3]  = '{8'h08, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0};
    vecs[4]  = '{8'h08, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[5]  = '{8'h00, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3};
    vecs[10] = '{8'h00, 1'b1, 8'h08, 8'h00, 1'b1, 3'd3};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0};

    tick(1);
    check_out("reset", 8'h00, 1'b0, 3'd0);
    check("reset_f4_pending", 32'(bus_f4.pending), 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      intr_in   = vecs[i].intr_in;
      clr_valid = vecs[i].clr_valid;
      clr_mask  = vecs[i].clr_mask;
      tick(1);
      check_out($sformatf("t1_row%0d", i), vecs[i].exp_pending, vecs[i].exp_irq, vecs[i].exp_id);
    end

    // T2: ch0 falling, ch1 both edges, 10-cycle pulse.
    do_reset();
    cfg_mode = 16'h555E;
    intr_in  = 8'h03;
    tick(3);
    check("t2_high3", 32'(bus.pending), 32'h00);
    tick(1);
    check("t2_rise_ch1", 32'(bus.pending), 32'h02);
    tick(6);
    check("t2_high10", 32'(bus.pending), 32'h02);
    intr_in = 8'h00;
    tick(3);
    check("t2_fall3", 32'(bus.pending), 32'h02);
    tick(1);
    check("t2_fall_ch0", 32'(bus.pending), 32'h03);
    tick(5);
    check_out("t2_settled", 8'h03, 1'b1, 3'd0);

    // T3: clear of an edge pending bit, then clear colliding with a new edge.
    do_reset();
    cfg_mode = 16'h5555;
    intr_in  = 8'h04;
    tick(5);
    check_out("t3_set", 8'h04, 1'b1, 3'd2);
    intr_in = 8'h00;
    tick(5);
    clr_valid = 1'b1;
    clr_mask  = 8'h04;
    tick(1);
    check_out("t3_clr", 8'h00, 1'b1, 3'd2);
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    tick(1);
    check_out("t3_clr_irq", 8'h00, 1'b0, 3'd0);
    intr_in = 8'h04;
    tick(3);
    clr_valid = 1'b1;
    clr_mask  = 8'h04;
    tick(1);
    check("t3_collide", 32'(bus.pending), 32'h04);
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    tick(1);
    check_out("t3_collide_after", 8'h04, 1'b1, 3'd2);

    // T4: 4-cycle filter, glitch rejected, long pulse accepted.
    do_reset();
    intr_in = 8'h01;
    tick(3);
    intr_in = 8'h00;
    tick(10);
    check("t4_glitch_pending", 32'(bus_f4.pending), 32'h00);
    check("t4_glitch_irq",     32'(bus_f4.irq),     32'h0);
    intr_in = 8'h01;
    tick(5);
    intr_in = 8'h00;
    tick(1);
    check("t4_edge6_pending", 32'(bus_f4.pending), 32'h00);
    tick(1);
    check("t4_edge7_pending", 32'(bus_f4.pending), 32'h01);
    check("t4_edge7_irq",     32'(bus_f4.irq),     32'h0);
    tick(1);
    check("t4_edge8_irq",     32'(bus_f4.irq),     32'h1);
    check("t4_edge8_id",      32'(bus_f4.irq_id),  32'h0);

    // T5: priority and masking via cfg_en.
    do_reset();
    intr_in = 8'h22;
    tick(5);
    check_out("t5_both", 8'h22, 1'b1, 3'd1);
    cfg_en = 8'hFD;
    tick(1);
    check_out("t5_mask1", 8'h22, 1'b1, 3'd5);
    cfg_en = 8'hFF;
    tick(1);
    check_out("t5_reen", 8'h22, 1'b1, 3'd1);

    // T6: level mode on ch7, clear ignored, follows the line; reset mid-pulse.
    do_reset();
    cfg_mode = 16'h1555;
    intr_in  = 8'h80;
    tick(4);
    check("t6_level_set", 32'(bus.pending), 32'h80);
    tick(1);
    check_out("t6_level_irq", 8'h80, 1'b1, 3'd7);
    clr_valid = 1'b1;
    clr_mask  = 8'h80;
    tick(1);
    check("t6_clr_ignored", 32'(bus.pending), 32'h80);
    clr_valid = 1'b0;
    clr_mask  = 8'h00;
    intr_in   = 8'h00;
    tick(3);
    check("t6_drop3", 32'(bus.pending), 32'h80);
    tick(1);
    check("t6_drop4", 32'(bus.pending), 32'h00);
    tick(1);
    check_out("t6_drop_irq", 8'h00, 1'b0, 3'd0);
    intr_in = 8'h80;
    tick(5);
    check_out("t6_pulse", 8'h80, 1'b1, 3'd7);
    rstn = 1'b0;
    tick(1);
    check_out("t6_midreset", 8'h00, 1'b0, 3'd0);
    check("t6_midreset_f4", 32'(bus_f4.pending), 32'h00);
    rstn    = 1'b1;
    intr_in = 8'h00;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
